// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int SEL_MAX = 5,
    parameter int STAT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_A,
    input  logic [WIDTH-1:0] req0_B,
    input  logic [3:0]       req0_sel,
    input  logic             req0_Cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_A,
    input  logic [WIDTH-1:0] req1_B,
    input  logic [3:0]       req1_sel,
    input  logic             req1_Cin,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [3:0]       alu_sel,
    output logic             alu_Cin,
    input  logic [WIDTH-1:0] alu_Y,
    input  logic             alu_Cout,
    input  logic             alu_Negative,
    input  logic             alu_Zero,
    input  logic             alu_Overflow,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_Y,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SEL_LIM = 4'(SEL_MAX);

    state_t           state;
    logic             rr_ptr;
    logic             owner;
    logic             err_pend;
    logic             grant1;
    logic             take;
    logic             bad_sel;
    logic [WIDTH-1:0] win_A;
    logic [WIDTH-1:0] win_B;
    logic [3:0]       win_sel;
    logic             win_cin;
    logic             own_ready;

    if (STAT_W < 1) begin : g_stat_chk
        $error("STAT_W must be at least 1");
    end

    // Requester 1 wins when it is alone or when the pointer favours it.
    always_comb begin
        grant1     = req1_valid && (!req0_valid || rr_ptr);
        req0_ready = !rst && (state == IDLE) && req0_valid && !grant1;
        req1_ready = !rst && (state == IDLE) && grant1;
        take       = req0_ready || req1_ready;
        win_A      = grant1 ? req1_A   : req0_A;
        win_B      = grant1 ? req1_B   : req0_B;
        win_sel    = grant1 ? req1_sel : req0_sel;
        win_cin    = grant1 ? req1_Cin : req0_Cin;
        bad_sel    = win_sel > SEL_LIM;
        own_ready  = owner ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            err_pend   <= 1'b0;
            alu_A      <= '0;
            alu_B      <= '0;
            alu_sel    <= '0;
            alu_Cin    <= 1'b0;
            rsp_Y      <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        alu_A    <= win_A;
                        alu_B    <= win_B;
                        alu_sel  <= bad_sel ? 4'd0 : win_sel;
                        alu_Cin  <= win_cin;
                        err_pend <= bad_sel;
                        owner    <= grant1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (err_pend) begin
                        rsp_Y     <= '0;
                        rsp_flags <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        rsp_Y     <= alu_Y;
                        rsp_flags <= {alu_Cout, alu_Negative,
                                      alu_Zero, alu_Overflow};
                        rsp_err   <= 1'b0;
                    end
                    rsp0_valid <= !owner;
                    rsp1_valid <= owner;
                    state      <= RESP;
                end
                RESP: begin
                    if (own_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        rr_ptr     <= ~owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
        end else begin
            if (req0_ready && !(&stat_grant0))
                stat_grant0 <= stat_grant0 + 1'b1;
            if (req1_ready && !(&stat_grant1))
                stat_grant1 <= stat_grant1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; the ALU is a small model here.
// Build with ALU_ARB_STATS_EN to include grant counter checks.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_Cin;
    logic [31:0] req0_A, req0_B;
    logic [3:0]  req0_sel;
    logic        req1_valid, req1_ready, req1_Cin;
    logic [31:0] req1_A, req1_B;
    logic [3:0]  req1_sel;
    logic [31:0] alu_A, alu_B, alu_Y;
    logic [3:0]  alu_sel;
    logic        alu_Cin, alu_Cout, alu_Negative, alu_Zero, alu_Overflow;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_Y;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [3:0]  s);
        case (s)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return ~a;
            4'd3:    return ~(a | b);
            4'd4:    return a ^ b;
            4'd5:    return ~(a & b);
            default: return '0;
        endcase
    endfunction

    assign alu_Y        = alu_fn(alu_A, alu_B, alu_sel);
    assign alu_Cout     = 1'b0;
    assign alu_Negative = alu_Y[31];
    assign alu_Zero     = (alu_Y == 32'd0);
    assign alu_Overflow = 1'b0;

    alu_share_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_A(req0_A), .req0_B(req0_B),
        .req0_sel(req0_sel), .req0_Cin(req0_Cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_A(req1_A), .req1_B(req1_B),
        .req1_sel(req1_sel), .req1_Cin(req1_Cin),
        .alu_A(alu_A), .alu_B(alu_B), .alu_sel(alu_sel), .alu_Cin(alu_Cin),
        .alu_Y(alu_Y), .alu_Cout(alu_Cout), .alu_Negative(alu_Negative),
        .alu_Zero(alu_Zero), .alu_Overflow(alu_Overflow),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_Y(rsp_Y), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 0; req0_A = 0; req0_B = 0; req0_sel = 0; req0_Cin = 0;
        req1_valid = 0; req1_A = 0; req1_B = 0; req1_sel = 0; req1_Cin = 0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_handshake: got %b want 0000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        n_cmp++;
        if ({alu_A, alu_B, alu_sel, alu_Cin} !== 69'd0) begin
            n_bad++;
            $display("FAIL reset_alu: got %h %h %h %b want zeros",
                     alu_A, alu_B, alu_sel, alu_Cin);
        end
        n_cmp++;
        if ({rsp_Y, rsp_flags, rsp_err} !== 37'd0) begin
            n_bad++;
            $display("FAIL reset_rsp: got %h %h %b want zeros",
                     rsp_Y, rsp_flags, rsp_err);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        req0_A = 32'hF0F0F0F0; req0_B = 32'hFF00FF00; req0_sel = 4'd0;
        req0_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp0_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early_valid: got %b want 0", rsp0_valid);
        end
        n_cmp++;
        if (alu_A !== 32'hF0F0F0F0) begin
            n_bad++;
            $display("FAIL single_alu_A: got %h want f0f0f0f0", alu_A);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp0_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_valid: got %b want 1", rsp0_valid);
        end
        n_cmp++;
        if ({rsp_Y, rsp_flags, rsp_err} !== {32'hF000F000, 4'b0100, 1'b0}) begin
            n_bad++;
            $display("FAIL single_rsp: got %h %b %b want f000f000 0100 0",
                     rsp_Y, rsp_flags, rsp_err);
        end
        tick();
    endtask

    task automatic test_contention();
        int         g = 0;
        int         nr = 0;
        logic [3:0] order = 4'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_A = 32'h0000FFFF; req0_B = 32'h00FF00FF; req0_sel = 4'd1;
        req1_A = 32'h12345678; req1_B = 32'h12345678; req1_sel = 4'd4;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ((req0_ready && req1_ready) || (rsp0_valid && rsp1_valid)) begin
                n_bad++;
                $display("FAIL cont_overlap: got rdy %b%b vld %b%b want no overlap",
                         req0_ready, req1_ready, rsp0_valid, rsp1_valid);
            end
            if ((req0_ready || req1_ready) && g < 4) begin
                order[g] = req1_ready;
                g++;
            end
            if (rsp0_valid) begin
                nr++;
                n_cmp++;
                if ({rsp_Y, rsp_flags} !== {32'h00FFFFFF, 4'b0000}) begin
                    n_bad++;
                    $display("FAIL cont_rsp0: got %h %b want 00ffffff 0000",
                             rsp_Y, rsp_flags);
                end
            end
            if (rsp1_valid) begin
                nr++;
                n_cmp++;
                if ({rsp_Y, rsp_flags} !== {32'h00000000, 4'b0010}) begin
                    n_bad++;
                    $display("FAIL cont_rsp1: got %h %b want 00000000 0010",
                             rsp_Y, rsp_flags);
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_cmp++;
        if (order !== 4'b1010 || g != 4) begin
            n_bad++;
            $display("FAIL cont_order: got %b (%0d grants) want 1010 (4)", order, g);
        end
        n_cmp++;
        if (nr != 4) begin
            n_bad++;
            $display("FAIL cont_rsp_count: got %0d want 4", nr);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp1_ready = 1'b0;
        req1_A = 32'hFFFF0000; req1_B = 32'h0; req1_sel = 4'd2;
        req1_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_grant: got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        req0_A = 32'h0; req0_B = 32'h0; req0_sel = 4'd3;
        req0_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({rsp1_valid, rsp0_valid, rsp_Y, rsp_flags, req0_ready, req1_ready}
                !== {2'b10, 32'h0000FFFF, 4'b0000, 2'b00}) begin
                n_bad++;
                $display("FAIL bp_hold: cyc %0d got v%b%b %h %b r%b%b want v10 0000ffff 0000 r00",
                         i, rsp1_valid, rsp0_valid, rsp_Y, rsp_flags,
                         req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, req0_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL bp_release: got %b want 01", {rsp1_valid, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp_Y, rsp_flags} !== {1'b1, 32'hFFFFFFFF, 4'b0100}) begin
            n_bad++;
            $display("FAIL bp_next: got %b %h %b want 1 ffffffff 0100",
                     rsp0_valid, rsp_Y, rsp_flags);
        end
        tick();
    endtask

    task automatic test_illegal();
        req1_A = 32'hFFFFFFFF; req1_B = 32'hFFFFFFFF; req1_sel = 4'b1001;
        req1_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req1_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_grant: got %b want 1", req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (alu_sel !== 4'd0) begin
            n_bad++;
            $display("FAIL ill_alu_sel: got %h want 0", alu_sel);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp1_valid, rsp_err, rsp_Y, rsp_flags} !== {2'b11, 32'h0, 4'b0}) begin
            n_bad++;
            $display("FAIL ill_rsp: got v%b e%b %h %b want v1 e1 00000000 0000",
                     rsp1_valid, rsp_err, rsp_Y, rsp_flags);
        end
        tick();
        req0_A = 32'hFFFFFFFF; req0_B = 32'hFFFFFFFF; req0_sel = 4'd0;
        req0_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ill_next_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp_err, rsp_Y, rsp_flags}
            !== {2'b10, 32'hFFFFFFFF, 4'b0100}) begin
            n_bad++;
            $display("FAIL ill_next_rsp: got v%b e%b %h %b want v1 e0 ffffffff 0100",
                     rsp0_valid, rsp_err, rsp_Y, rsp_flags);
        end
        tick();
    endtask

    task automatic test_reset_resp();
        rsp0_ready = 1'b0;
        req0_A = 32'h0F0F0F0F; req0_B = 32'h0; req0_sel = 4'd1;
        req0_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_grant: got %b want 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp_Y} !== {1'b1, 32'h0F0F0F0F}) begin
            n_bad++;
            $display("FAIL rr_pre_valid: got %b %h want 1 0f0f0f0f", rsp0_valid, rsp_Y);
        end
`ifdef ALU_ARB_STATS_EN
        n_cmp++;
        if ({stat_grant0, stat_grant1} !== {16'd5, 16'd4}) begin
            n_bad++;
            $display("FAIL stat_count: got %0d %0d want 5 4", stat_grant0, stat_grant1);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp1_valid, rsp_Y, alu_A} !== 66'd0) begin
            n_bad++;
            $display("FAIL rr_abandon: got v%b%b %h %h want zeros",
                     rsp0_valid, rsp1_valid, rsp_Y, alu_A);
        end
`ifdef ALU_ARB_STATS_EN
        n_cmp++;
        if ({stat_grant0, stat_grant1} !== 32'd0) begin
            n_bad++;
            $display("FAIL stat_clear: got %0d %0d want 0 0", stat_grant0, stat_grant1);
        end
`endif
        rst = 1'b0;
        rsp0_ready = 1'b1;
        req0_A = 32'h1; req0_B = 32'h2; req0_sel = 4'd4;
        req1_A = 32'h5; req1_B = 32'h6; req1_sel = 4'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL rr_ptr_reset: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp1_valid, rsp_Y} !== {2'b10, 32'h3}) begin
            n_bad++;
            $display("FAIL rr_post_rsp: got v%b%b %h want v10 00000003",
                     rsp0_valid, rsp1_valid, rsp_Y);
        end
`ifdef ALU_ARB_STATS_EN
        n_cmp++;
        if ({stat_grant0, stat_grant1} !== {16'd1, 16'd0}) begin
            n_bad++;
            $display("FAIL stat_after: got %0d %0d want 1 0", stat_grant0, stat_grant1);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
